// File: rtl/pipeline_control_unit.sv
// RV32I main decoder with EX/MEM/WB control-bundle registers, load-use stall,
// branch/jump flush and saturating stall/flush performance counters.
module pipeline_control_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned EN_JUMP    = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    output logic                  stall_pc,
    output logic                  flush_ifid,
    output logic                  id_illegal,
    output logic                  ex_valid,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_alusrc,
    output logic                  ex_regwrite,
    output logic                  ex_memtoreg,
    output logic [1:0]            ex_aluop,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  mem_regwrite,
    output logic                  mem_memtoreg,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic                  valid;
        logic                  branch;
        logic                  jump;
        logic                  memread;
        logic                  memwrite;
        logic                  alusrc;
        logic                  regwrite;
        logic                  memtoreg;
        logic [1:0]            aluop;
        logic [REG_ADDR_W-1:0] rd;
    } ex_bundle_t;

    typedef struct packed {
        logic                  valid;
        logic                  memread;
        logic                  memwrite;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
    } mem_bundle_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
    } wb_bundle_t;

    ex_bundle_t  dec, ex_d, ex_q;
    mem_bundle_t mem_d, mem_q;
    wb_bundle_t  wb_d, wb_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
    logic legal, use_rs1, use_rs2, hz, fl;

    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011: begin
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b10;
                use_rs2      = 1'b1;
            end
            7'b0000011: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            7'b0100011: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                use_rs2      = 1'b1;
            end
            7'b1100011: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b01;
                use_rs2    = 1'b1;
            end
            7'b0010011: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b11;
            end
            7'b1101111: begin
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
                use_rs1      = 1'b0;
            end
            7'b1100111: begin
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                use_rs1      = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        // With jumps disabled the whole jump/upper-immediate group becomes illegal
        if (EN_JUMP == 0 && (id_opcode == 7'b1101111 || id_opcode == 7'b1100111 ||
                             id_opcode == 7'b0110111 || id_opcode == 7'b0010111)) begin
            legal = 1'b0;
        end
        if (!legal) begin
            dec     = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end else begin
            dec.valid = 1'b1;
            dec.rd    = id_rd;
            if (id_rd == '0) dec.regwrite = 1'b0;
        end
    end

    always_comb begin
        hz = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
             ((use_rs1 & (ex_q.rd == id_rs1)) | (use_rs2 & (ex_q.rd == id_rs2)));
        fl = ex_q.valid & ex_redirect;
        ex_d  = (fl || hz || !id_valid || !legal) ? '0 : dec;
        mem_d = '{valid: ex_q.valid, memread: ex_q.memread, memwrite: ex_q.memwrite,
                  regwrite: ex_q.regwrite, memtoreg: ex_q.memtoreg, rd: ex_q.rd};
        wb_d  = '{valid: mem_q.valid, regwrite: mem_q.regwrite,
                  memtoreg: mem_q.memtoreg, rd: mem_q.rd};
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz && !fl && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (fl && flush_cnt_q != '1)        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_pc     = hz & ~fl;
    assign flush_ifid   = fl;
    assign id_illegal   = id_valid & ~legal;
    assign ex_valid     = ex_q.valid;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_memread   = ex_q.memread;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_aluop     = ex_q.aluop;
    assign ex_rd        = ex_q.rd;
    assign mem_valid    = mem_q.valid;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_memtoreg = mem_q.memtoreg;
    assign mem_rd       = mem_q.rd;
    assign wb_valid     = wb_q.valid;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_rd        = wb_q.rd;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: default instance plus a second
// instance with jumps disabled and 2-bit counters, both fed the same stimulus.
module tb_pipeline_control_unit;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                           OP_BR = 7'b1100011, OP_IA = 7'b0010011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst, id_valid, ex_redirect;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic stall_pc, flush_ifid, id_illegal;
    logic ex_valid, ex_branch, ex_jump, ex_memread, ex_memwrite, ex_alusrc, ex_regwrite, ex_memtoreg;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
    logic wb_valid, wb_regwrite, wb_memtoreg;
    logic [15:0] stall_cnt, flush_cnt;

    logic d2_stall_pc, d2_flush_ifid, d2_id_illegal;
    logic d2_ex_valid, d2_ex_branch, d2_ex_jump, d2_ex_memread, d2_ex_memwrite, d2_ex_alusrc;
    logic d2_ex_regwrite, d2_ex_memtoreg;
    logic [1:0] d2_ex_aluop;
    logic [4:0] d2_ex_rd, d2_mem_rd, d2_wb_rd;
    logic d2_mem_valid, d2_mem_memread, d2_mem_memwrite, d2_mem_regwrite, d2_mem_memtoreg;
    logic d2_wb_valid, d2_wb_regwrite, d2_wb_memtoreg;
    logic [1:0] d2_stall_cnt, d2_flush_cnt;

    always #5 clk = ~clk;

    pipeline_control_unit #(.REG_ADDR_W(5), .EN_JUMP(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall_pc(stall_pc), .flush_ifid(flush_ifid), .id_illegal(id_illegal),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop),
        .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
        .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_control_unit #(.REG_ADDR_W(5), .EN_JUMP(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall_pc(d2_stall_pc), .flush_ifid(d2_flush_ifid), .id_illegal(d2_id_illegal),
        .ex_valid(d2_ex_valid), .ex_branch(d2_ex_branch), .ex_jump(d2_ex_jump),
        .ex_memread(d2_ex_memread), .ex_memwrite(d2_ex_memwrite), .ex_alusrc(d2_ex_alusrc),
        .ex_regwrite(d2_ex_regwrite), .ex_memtoreg(d2_ex_memtoreg), .ex_aluop(d2_ex_aluop),
        .ex_rd(d2_ex_rd), .mem_valid(d2_mem_valid), .mem_memread(d2_mem_memread),
        .mem_memwrite(d2_mem_memwrite), .mem_regwrite(d2_mem_regwrite),
        .mem_memtoreg(d2_mem_memtoreg), .mem_rd(d2_mem_rd), .wb_valid(d2_wb_valid),
        .wb_regwrite(d2_wb_regwrite), .wb_memtoreg(d2_wb_memtoreg), .wb_rd(d2_wb_rd),
        .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    // bundle bit order: {valid,branch,jump,memread,memwrite,alusrc,regwrite,memtoreg,aluop[1:0]}
    typedef struct {
        logic [6:0] op;
        logic [4:0] rd;
        logic [9:0] exp_bundle;
        logic       exp_ill;
        logic       exp_ill2;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic redir);
        id_valid    = v;
        id_opcode   = op;
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        ex_redirect = redir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ex_bus();
        return {ex_valid, ex_branch, ex_jump, ex_memread, ex_memwrite, ex_alusrc,
                ex_regwrite, ex_memtoreg, ex_aluop};
    endfunction

    function automatic logic [9:0] d2_ex_bus();
        return {d2_ex_valid, d2_ex_branch, d2_ex_jump, d2_ex_memread, d2_ex_memwrite,
                d2_ex_alusrc, d2_ex_regwrite, d2_ex_memtoreg, d2_ex_aluop};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{OP_R,     5'd3, 10'b1_0_0_0_0_0_1_0_10, 1'b0, 1'b0};
        vecs[1]  = '{OP_LD,    5'd5, 10'b1_0_0_1_0_1_1_1_00, 1'b0, 1'b0};
        vecs[2]  = '{OP_ST,    5'd0, 10'b1_0_0_0_1_1_0_0_00, 1'b0, 1'b0};
        vecs[3]  = '{OP_BR,    5'd0, 10'b1_1_0_0_0_0_0_0_01, 1'b0, 1'b0};
        vecs[4]  = '{OP_IA,    5'd7, 10'b1_0_0_0_0_1_1_0_11, 1'b0, 1'b0};
        vecs[5]  = '{OP_JAL,   5'd1, 10'b1_0_1_0_0_0_1_0_00, 1'b0, 1'b1};
        vecs[6]  = '{OP_JALR,  5'd1, 10'b1_0_1_0_0_1_1_0_00, 1'b0, 1'b1};
        vecs[7]  = '{OP_LUI,   5'd2, 10'b1_0_0_0_0_1_1_0_00, 1'b0, 1'b1};
        vecs[8]  = '{OP_AUIPC, 5'd4, 10'b1_0_0_0_0_1_1_0_00, 1'b0, 1'b1};
        vecs[9]  = '{OP_R,     5'd0, 10'b1_0_0_0_0_0_0_0_10, 1'b0, 1'b0};
        vecs[10] = '{OP_BAD,   5'd3, 10'b0,                  1'b1, 1'b1};

        // reset state
        rst = 1'b1;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        check("rst_ex_bus", 32'(ex_bus()), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rst_stall_pc", 32'(stall_pc), 32'd0);
        check("rst_flush_ifid", 32'(flush_ifid), 32'd0);
        rst = 1'b0;

        // decode table (rs fields 0 so no hazard can arise)
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].rd, 5'd0, 5'd0, 1'b0);
            #1;
            check($sformatf("illegal[%0d]", i), 32'(id_illegal), 32'(vecs[i].exp_ill));
            check($sformatf("illegal_nojump[%0d]", i), 32'(d2_id_illegal), 32'(vecs[i].exp_ill2));
            tick();
            check($sformatf("ex_bus[%0d]", i), 32'(ex_bus()), 32'(vecs[i].exp_bundle));
            check($sformatf("ex_rd[%0d]", i), 32'(ex_rd),
                  vecs[i].exp_bundle[9] ? 32'(vecs[i].rd) : 32'd0);
            check($sformatf("ex_bus_nojump[%0d]", i), 32'(d2_ex_bus()),
                  vecs[i].exp_ill2 ? 32'd0 : 32'(vecs[i].exp_bundle));
        end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // T1: add x3,x1,x2 then idle, follow it down the pipe
        drive(1'b1, OP_R, 5'd3, 5'd1, 5'd2, 1'b0);
        tick();
        check("t1_ex_regwrite", 32'(ex_regwrite), 32'd1);
        check("t1_ex_aluop", 32'(ex_aluop), 32'd2);
        check("t1_ex_rd", 32'(ex_rd), 32'd3);
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("t1_mem_regwrite", 32'(mem_regwrite), 32'd1);
        check("t1_mem_rd", 32'(mem_rd), 32'd3);
        check("t1_ex_idle", 32'(ex_valid), 32'd0);
        tick();
        check("t1_wb_valid", 32'(wb_valid), 32'd1);
        check("t1_wb_regwrite", 32'(wb_regwrite), 32'd1);
        check("t1_wb_rd", 32'(wb_rd), 32'd3);
        check("t1_wb_memtoreg", 32'(wb_memtoreg), 32'd0);

        // T2: lw x5 then add x6,x5,x1 -> one stall cycle
        drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b0);
        #1;
        check("t2_stall_pc", 32'(stall_pc), 32'd1);
        check("t2_no_flush", 32'(flush_ifid), 32'd0);
        tick();
        check("t2_ex_bubble", 32'(ex_valid), 32'd0);
        check("t2_stall_cnt", 32'(stall_cnt), 32'd1);
        check("t2_stall_released", 32'(stall_pc), 32'd0);
        check("t2_mem_load", 32'(mem_memread), 32'd1);
        tick();
        check("t2_add_ex_valid", 32'(ex_valid), 32'd1);
        check("t2_add_ex_rd", 32'(ex_rd), 32'd6);
        check("t2_mem_bubble", 32'(mem_valid), 32'd0);
        check("t2_stall_cnt_hold", 32'(stall_cnt), 32'd1);
        check("t2_stall_cnt_w2", 32'(d2_stall_cnt), 32'd1);

        // T3: lw x5 then lui x5 (rs1 unused); lw x0 then add x1,x0,x0
        drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_LUI, 5'd5, 5'd5, 5'd5, 1'b0);
        #1;
        check("t3_lui_no_stall", 32'(stall_pc), 32'd0);
        tick();
        check("t3_lui_ex_valid", 32'(ex_valid), 32'd1);
        drive(1'b1, OP_LD, 5'd0, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, 5'd1, 5'd0, 5'd0, 1'b0);
        #1;
        check("t3_x0_no_stall", 32'(stall_pc), 32'd0);
        tick();
        check("t3_x0_add_ex_rd", 32'(ex_rd), 32'd1);
        check("t3_stall_cnt", 32'(stall_cnt), 32'd1);

        // T4: redirect coincides with a load-use hazard
        drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b1);
        #1;
        check("t4_flush_ifid", 32'(flush_ifid), 32'd1);
        check("t4_stall_pc", 32'(stall_pc), 32'd0);
        tick();
        check("t4_ex_bubble", 32'(ex_valid), 32'd0);
        check("t4_flush_cnt", 32'(flush_cnt), 32'd1);
        check("t4_stall_cnt", 32'(stall_cnt), 32'd1);
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("t4_flush_drops", 32'(flush_ifid), 32'd0);

        // T6a: reset with three instructions in flight
        drive(1'b1, OP_R, 5'd3, 5'd1, 5'd2, 1'b0);
        tick();
        drive(1'b1, OP_LD, 5'd4, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, 5'd5, 5'd1, 5'd2, 1'b0);
        tick();
        check("t6_full_pipe", 32'({ex_valid, mem_valid, wb_valid}), 32'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'h0);
        check("t6_wb_rd", 32'(wb_rd), 32'd0);
        check("t6_mem_memread", 32'(mem_memread), 32'd0);
        check("t6_stall_cnt", 32'(stall_cnt), 32'd0);
        check("t6_flush_cnt", 32'(flush_cnt), 32'd0);
        check("t6_valids_w2", 32'({d2_ex_valid, d2_mem_valid, d2_wb_valid}), 32'h0);

        // T6b: five load-use stalls; 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0);
            tick();
            drive(1'b1, OP_R, 5'd6, 5'd5, 5'd1, 1'b0);
            tick();
            tick();
        end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("t6_stall_cnt_16", 32'(stall_cnt), 32'd5);
        check("t6_stall_cnt_sat", 32'(d2_stall_cnt), 32'd3);
        check("t6_flush_cnt_w2", 32'(d2_flush_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
